// File: rtl/id_pkg.sv
// id_pkg: shared defaults, control-bit positions and ID/EX control record for the decode stage.
package id_pkg;
   localparam int DEF_DATA_W = 64;
   localparam int DEF_REG_ADDR_W = 5;
   localparam int DEF_ZERO_REG = 31;
   localparam int CTRL_W = 8;
   localparam int C_REGWRITE = 7;
   localparam int C_MEMWRITE = 6;
   localparam int C_MEMREAD = 5;
   localparam int C_MEMTOREG = 4;
   localparam int C_ALUSRC = 3;
   localparam int C_ALUOP = 0;
   typedef struct packed {
      logic              valid;
      logic              bl;
      logic [CTRL_W-1:0] ctrl;
   } id_ex_t;
   localparam id_ex_t BUBBLE = '0;
   function automatic logic is_mem(input logic [CTRL_W-1:0] c);
      return c[C_MEMREAD] | c[C_MEMWRITE];
   endfunction
endpackage

// File: rtl/id_fwd_mux.sv
// id_fwd_mux: one read port's operand select (zero reg, EX, MEM, WB write-through, register file).
module id_fwd_mux
   import id_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int ZERO_REG = DEF_ZERO_REG
) (
   input  logic [REG_ADDR_W-1:0] addr,
   input  logic                  ex_fwd_en,
   input  logic [REG_ADDR_W-1:0] ex_fwd_addr,
   input  logic [DATA_W-1:0]     ex_fwd_data,
   input  logic                  ex_is_load,
   input  logic                  mem_fwd_en,
   input  logic [REG_ADDR_W-1:0] mem_fwd_addr,
   input  logic [DATA_W-1:0]     mem_fwd_data,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic [DATA_W-1:0]     rf_data,
   output logic [DATA_W-1:0]     data
);
   localparam logic [REG_ADDR_W-1:0] ZR = REG_ADDR_W'(ZERO_REG);
   // a load's EX result is the address, not the data, so it must never be forwarded
   assign data = (addr == ZR) ? '0 :
                 (ex_fwd_en && !ex_is_load && ex_fwd_addr == addr) ? ex_fwd_data :
                 (mem_fwd_en && mem_fwd_addr == addr) ? mem_fwd_data :
                 (wb_en && wb_addr == addr) ? wb_data : rf_data;
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: pipelined decode/operand fetch with forwarding, load-use stall and ID/EX register.
// Define ID_BRANCH_RESOLVE_EN to add combinational br_taken_id/br_target_id outputs.
module id_stage_pipe
   import id_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int NUM_REGS = 32,
   parameter int ZERO_REG = DEF_ZERO_REG
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [DATA_W-1:0]     pc_in,
   input  logic [REG_ADDR_W-1:0] Rn,
   input  logic [REG_ADDR_W-1:0] Rm,
   input  logic [REG_ADDR_W-1:0] Rd,
   input  logic                  Reg2Loc,
   input  logic                  UnCondBr,
   input  logic                  BLsignal,
   input  logic [CTRL_W-1:0]     ctrl_in,
   input  logic [18:0]           cond_br_addr,
   input  logic [25:0]           br_addr,
   input  logic [11:0]           imm_in,
   input  logic [8:0]            dt_addr,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  ex_fwd_en,
   input  logic [REG_ADDR_W-1:0] ex_fwd_addr,
   input  logic [DATA_W-1:0]     ex_fwd_data,
   input  logic                  ex_is_load,
   input  logic                  mem_fwd_en,
   input  logic [REG_ADDR_W-1:0] mem_fwd_addr,
   input  logic [DATA_W-1:0]     mem_fwd_data,
   input  logic                  flush,
   output logic                  stall_out,
   output logic                  ex_valid,
   output logic [DATA_W-1:0]     ex_pc,
   output logic [DATA_W-1:0]     ex_da,
   output logic [DATA_W-1:0]     ex_db,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [DATA_W-1:0]     ex_br_off,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [CTRL_W-1:0]     ex_ctrl,
   output logic                  ex_bl
`ifdef ID_BRANCH_RESOLVE_EN
   ,
   output logic                  br_taken_id,
   output logic [DATA_W-1:0]     br_target_id
`endif
);
   localparam logic [REG_ADDR_W-1:0] ZR = REG_ADDR_W'(ZERO_REG);
   logic [DATA_W-1:0] rf [NUM_REGS];
   logic [REG_ADDR_W-1:0] ab;
   logic [DATA_W-1:0] da, db, imm, br_off;
   logic hazard, live;
   id_ex_t nxt, cur;
   assign ab = Reg2Loc ? Rm : Rd;
   assign hazard = !reset && id_valid && ex_is_load && ex_fwd_addr != ZR &&
                   (ex_fwd_addr == Rn || ex_fwd_addr == ab);
   assign stall_out = hazard && !flush;
   assign live = id_valid && !flush && !hazard;
   assign imm = is_mem(ctrl_in) ? DATA_W'($signed(dt_addr)) : DATA_W'(imm_in);
   assign br_off = (UnCondBr ? DATA_W'($signed(br_addr)) : DATA_W'($signed(cond_br_addr))) << 2;
   assign nxt = live ? '{valid: 1'b1, bl: BLsignal, ctrl: ctrl_in} : BUBBLE;
   id_fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_fwd_a (
      .addr(Rn), .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
      .ex_is_load(ex_is_load), .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr),
      .mem_fwd_data(mem_fwd_data), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .rf_data(rf[Rn]), .data(da)
   );
   id_fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_fwd_b (
      .addr(ab), .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
      .ex_is_load(ex_is_load), .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr),
      .mem_fwd_data(mem_fwd_data), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .rf_data(rf[ab]), .data(db)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (wb_en && wb_addr != ZR) begin
         rf[wb_addr] <= wb_data;
      end
   end
   // data fields load every cycle; only the control record distinguishes a bubble
   always_ff @(posedge clk) begin
      if (reset) begin
         cur <= BUBBLE;
         ex_pc <= '0;
         ex_da <= '0;
         ex_db <= '0;
         ex_imm <= '0;
         ex_br_off <= '0;
         ex_rd <= '0;
      end else begin
         cur <= nxt;
         ex_pc <= pc_in;
         ex_da <= da;
         ex_db <= db;
         ex_imm <= imm;
         ex_br_off <= br_off;
         ex_rd <= Rd;
      end
   end
   assign ex_valid = cur.valid;
   assign ex_bl = cur.bl;
   assign ex_ctrl = cur.ctrl;
`ifdef ID_BRANCH_RESOLVE_EN
   assign br_target_id = pc_in + br_off;
   assign br_taken_id = id_valid && !stall_out && !flush && (UnCondBr || db == '0);
`endif
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed vectors with a queued scoreboard checked by a separate monitor.
module tb_id_stage_pipe;
   logic clk = 0, reset, id_valid, Reg2Loc, UnCondBr, BLsignal;
   logic [63:0] pc_in, wb_data, ex_fwd_data, mem_fwd_data;
   logic [4:0] Rn, Rm, Rd, wb_addr, ex_fwd_addr, mem_fwd_addr;
   logic [7:0] ctrl_in;
   logic [18:0] cond_br_addr;
   logic [25:0] br_addr;
   logic [11:0] imm_in;
   logic [8:0] dt_addr;
   logic wb_en, ex_fwd_en, ex_is_load, mem_fwd_en, flush;
   logic stall_out, ex_valid, ex_bl;
   logic [63:0] ex_pc, ex_da, ex_db, ex_imm, ex_br_off;
   logic [4:0] ex_rd;
   logic [7:0] ex_ctrl;
`ifdef ID_BRANCH_RESOLVE_EN
   logic br_taken_id;
   logic [63:0] br_target_id;
`endif
   typedef struct packed {
      logic full, rst, valid, bl, stall, unc;
      logic [7:0] ctrl;
      logic [4:0] rd;
      logic [63:0] pc, da, db, imm, boff, tgt;
   } exp_t;
   exp_t q[$];
   string qn[$];
   exp_t e, m;
   string mn;
   int nv = 0, nf = 0;

   id_stage_pipe dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .pc_in(pc_in), .Rn(Rn), .Rm(Rm), .Rd(Rd),
      .Reg2Loc(Reg2Loc), .UnCondBr(UnCondBr), .BLsignal(BLsignal), .ctrl_in(ctrl_in),
      .cond_br_addr(cond_br_addr), .br_addr(br_addr), .imm_in(imm_in), .dt_addr(dt_addr),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .ex_fwd_en(ex_fwd_en),
      .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data), .ex_is_load(ex_is_load),
      .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
      .flush(flush), .stall_out(stall_out), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_da(ex_da),
      .ex_db(ex_db), .ex_imm(ex_imm), .ex_br_off(ex_br_off), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
      .ex_bl(ex_bl)
`ifdef ID_BRANCH_RESOLVE_EN
      , .br_taken_id(br_taken_id), .br_target_id(br_target_id)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
      nv++;
      if (a !== x) begin
         nf++;
         $display("FAIL %s got %h expected %h", n, a, x);
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         m = q.pop_front();
         mn = qn.pop_front();
         chk({mn, ".valid"}, 64'(ex_valid), 64'(m.valid));
         chk({mn, ".ctrl"}, 64'(ex_ctrl), 64'(m.ctrl));
         chk({mn, ".bl"}, 64'(ex_bl), 64'(m.bl));
         chk({mn, ".stall"}, 64'(stall_out), 64'(m.stall));
         if (m.full) begin
            chk({mn, ".pc"}, ex_pc, m.pc);
            chk({mn, ".da"}, ex_da, m.da);
            chk({mn, ".db"}, ex_db, m.db);
            chk({mn, ".imm"}, ex_imm, m.imm);
            chk({mn, ".br_off"}, ex_br_off, m.boff);
            chk({mn, ".rd"}, 64'(ex_rd), 64'(m.rd));
         end
`ifdef ID_BRANCH_RESOLVE_EN
         if (!m.rst) chk({mn, ".taken"}, 64'(br_taken_id), 64'(m.valid & (m.unc | (m.db == 0))));
         if (m.full && m.valid) chk({mn, ".target"}, br_target_id, m.tgt);
`endif
      end
   end

   task automatic nx();
      @(negedge clk);
      reset = 0; id_valid = 1; pc_in = 0; Rn = 0; Rm = 0; Rd = 0; Reg2Loc = 1; UnCondBr = 1;
      BLsignal = 0; ctrl_in = 0; cond_br_addr = 0; br_addr = 0; imm_in = 0; dt_addr = 0;
      wb_en = 0; wb_addr = 0; wb_data = 0; ex_fwd_en = 0; ex_fwd_addr = 0; ex_fwd_data = 0;
      ex_is_load = 0; mem_fwd_en = 0; mem_fwd_addr = 0; mem_fwd_data = 0; flush = 0;
      e = '0; e.full = 1; e.valid = 1;
   endtask

   task automatic go(input string n);
      e.unc = UnCondBr;
      e.tgt = pc_in + e.boff;
      q.push_back(e);
      qn.push_back(n);
   endtask

   task automatic bubble(input logic st);
      e.full = 0; e.valid = 0; e.stall = st;
   endtask

   task automatic load_use_inputs();
      ex_is_load = 1; ex_fwd_en = 1; ex_fwd_addr = 7; ex_fwd_data = 64'h99;
      Rn = 7; ctrl_in = 8'hFF; BLsignal = 1;
   endtask

   initial begin
      nx(); reset = 1; id_valid = 0; e.valid = 0; e.rst = 1; go("reset");
      nx(); Rn = 5; Rm = 5; Rd = 9; ctrl_in = 8'h80; BLsignal = 1; pc_in = 64'h40;
      e.ctrl = 8'h80; e.bl = 1; e.pc = 64'h40; e.rd = 9; go("read_x5");
      nx(); wb_en = 1; wb_addr = 31; wb_data = 64'hFF; Rn = 31; Rm = 31; go("wr_x31");
      nx(); Rn = 31; Rm = 31; go("rd_x31");
      nx(); wb_en = 1; wb_addr = 3; wb_data = 64'hABCD; Rn = 3; e.da = 64'hABCD; go("wt_x3");
      nx(); Rn = 3; Rm = 3; e.da = 64'hABCD; e.db = 64'hABCD; go("rf_x3");
      nx(); ex_fwd_en = 1; ex_fwd_addr = 4; ex_fwd_data = 64'h11; mem_fwd_en = 1; mem_fwd_addr = 4;
      mem_fwd_data = 64'h22; wb_en = 1; wb_addr = 4; wb_data = 64'h33; Rn = 4; Rm = 4;
      e.da = 64'h11; e.db = 64'h11; go("ex_prio");
      nx(); mem_fwd_en = 1; mem_fwd_addr = 4; mem_fwd_data = 64'h22; wb_en = 1; wb_addr = 4;
      wb_data = 64'h33; Rn = 4; Rm = 4; Reg2Loc = 0; Rd = 3;
      e.da = 64'h22; e.db = 64'hABCD; e.rd = 3; go("mem_prio");
      nx(); ex_is_load = 1; ex_fwd_en = 1; ex_fwd_addr = 31; ex_fwd_data = 64'h55; Rn = 31; Rm = 4;
      e.db = 64'h33; go("load_zr");
      nx(); load_use_inputs(); bubble(1); go("load_use_rn");
      nx(); load_use_inputs(); Rn = 1; Rm = 2; Reg2Loc = 0; Rd = 7; bubble(1); go("load_use_ab");
      nx(); load_use_inputs(); flush = 1; bubble(0); go("flush_stall");
      nx(); UnCondBr = 0; cond_br_addr = 19'h7FFFF; pc_in = 64'h100; Reg2Loc = 0; Rd = 31;
      e.pc = 64'h100; e.rd = 31; e.boff = 64'hFFFF_FFFF_FFFF_FFFC; go("cbr_neg");
      nx(); br_addr = 26'h10; cond_br_addr = 19'h7FFFF; pc_in = 64'h100;
      e.pc = 64'h100; e.boff = 64'h40; go("ubr");
      nx(); UnCondBr = 0; cond_br_addr = 19'h1; pc_in = 64'h100; Rm = 3;
      e.pc = 64'h100; e.boff = 64'h4; e.db = 64'hABCD; go("cbr_nt");
      nx(); br_addr = 26'h2000000; e.boff = 64'hFFFF_FFFF_F800_0000; go("ubr_min");
      nx(); ctrl_in = 8'h20; dt_addr = 9'h1FF; imm_in = 12'hABC;
      e.ctrl = 8'h20; e.imm = 64'hFFFF_FFFF_FFFF_FFFF; go("dt_imm");
      nx(); ctrl_in = 8'h08; dt_addr = 9'h1FF; imm_in = 12'hFFF; e.ctrl = 8'h08; e.imm = 64'hFFF;
      go("alu_imm");
      nx(); id_valid = 0; ctrl_in = 8'hFF; BLsignal = 1; bubble(0); go("no_valid");
      nx(); load_use_inputs(); bubble(1); go("pre_rst");
      nx(); load_use_inputs(); reset = 1; e.valid = 0; e.rst = 1; go("rst_stall");
      nx(); Rn = 3; Rm = 4; go("rd_after_rst");
      repeat (3) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         nf++;
         $display("FAIL drain got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
      $finish;
   end
endmodule
